// File: rtl/disp_pkg.sv
// Shared constants and types for the multiplexed 7-segment display scanner.
package disp_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int PWM_STEPS  = 15;

  localparam logic [7:0] SEG_OFF    = 8'hFF;
  localparam logic [5:0] DIGIT_NONE = 6'h3F;

  // Active-low one-hot digit selects; element i pulls bit i low.
  localparam logic [NUM_DIGITS-1:0][5:0] DIGIT_SEL = {
    6'b011111,
    6'b101111,
    6'b110111,
    6'b111011,
    6'b111101,
    6'b111110
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } scan_state_t;

  // Width helper: a counter for N states never collapses to zero bits.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/disp_pwm.sv
// PWM step counter for one drive slot and the "lit" decision for the next cycle.
module disp_pwm
  import disp_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       drive_next,
  input  logic       drive_entry,
  input  logic [3:0] brightness,
  output logic       lit_next
);

  localparam logic [3:0] PWM_LAST = 4'(PWM_STEPS - 1);

  logic [3:0] cnt;
  logic [3:0] cnt_next;

  // Next count: restart at 0 on slot entry, wrap after the last step, park at 0 outside DRIVE.
  always_comb begin
    cnt_next = '0;
    if (drive_next && !drive_entry) begin
      cnt_next = (cnt == PWM_LAST) ? 4'd0 : cnt + 4'd1;
    end
  end

  // Lit when the step is below the duty level, so 0 never lights and 15 always does.
  assign lit_next = drive_next && (cnt_next < brightness);

  // Step counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Frame-buffered scan scheduler for a 6-digit multiplexed 7-segment display.
// Producers fill a back buffer and request a commit; the back buffer is copied
// to the front buffer only at frame boundaries (or at once while idle).
//
// Write handshake: a write (and/or commit) transfers on a rising clk edge where
// wr_valid (or wr_commit) and wr_ready are both 1. wr_ready depends only on
// internal state, never combinationally on wr_valid/wr_commit. Once a commit is
// accepted, wr_ready stays low until the swap has happened.
module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 64,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [2:0] wr_idx,
  input  logic [7:0] wr_seg,
  input  logic       wr_commit,
  input  logic [3:0] brightness,
  input  logic [5:0] blink_mask,
  output logic [7:0] seg,
  output logic [5:0] digit_sel,
  output logic       frame_tick
);

  localparam int DW = cnt_width(DWELL_CYCLES);
  localparam int BW = cnt_width(BLANK_CYCLES);
  localparam int KW = cnt_width(BLINK_FRAMES);

  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);
  localparam logic [KW-1:0] BLINK_LAST = KW'(BLINK_FRAMES - 1);
  localparam logic [2:0]    IDX_LAST   = 3'(NUM_DIGITS - 1);

  // Scan state
  scan_state_t   state, state_next;
  logic [DW-1:0] dwell_cnt, dwell_next;
  logic [BW-1:0] blank_cnt, blank_next;
  logic [2:0]    idx, idx_next;
  logic          tick_next;

  // Blink state
  logic [KW-1:0] blink_cnt, blink_cnt_next;
  logic          blink_phase, blink_phase_next;

  // Buffers and commit tracking
  logic [7:0] front      [NUM_DIGITS];
  logic [7:0] back       [NUM_DIGITS];
  logic [7:0] front_next [NUM_DIGITS];
  logic [7:0] back_next  [NUM_DIGITS];
  logic       pending, pending_next;
  logic       accept_wr, accept_commit, swap;

  // Output shaping
  logic       drive_next, drive_entry, pwm_lit_next, show_next;
  logic [7:0] seg_next;
  logic [5:0] digit_sel_next;

  // Scan FSM next state: BLANK gap, then DRIVE dwell, advancing the digit index.
  always_comb begin
    state_next = state;
    dwell_next = dwell_cnt;
    blank_next = blank_cnt;
    idx_next   = idx;
    tick_next  = 1'b0;
    if (!enable) begin
      state_next = IDLE;
      dwell_next = '0;
      blank_next = '0;
      idx_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_next = BLANK;
          blank_next = '0;
        end
        BLANK: begin
          if (blank_cnt == BLANK_LAST) begin
            state_next = DRIVE;
            blank_next = '0;
            dwell_next = '0;
          end else begin
            blank_next = blank_cnt + BW'(1);
          end
        end
        DRIVE: begin
          if (dwell_cnt == DWELL_LAST) begin
            state_next = BLANK;
            dwell_next = '0;
            tick_next  = (idx == IDX_LAST);
            idx_next   = (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
          end else begin
            dwell_next = dwell_cnt + DW'(1);
          end
        end
        default: begin
          state_next = IDLE;
          dwell_next = '0;
          blank_next = '0;
          idx_next   = '0;
        end
      endcase
    end
  end

  // Scan FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      dwell_cnt <= '0;
      blank_cnt <= '0;
      idx       <= '0;
    end else begin
      state     <= state_next;
      dwell_cnt <= dwell_next;
      blank_cnt <= blank_next;
      idx       <= idx_next;
    end
  end

  // Blink phase advances on frame ticks; the frame count restarts when scanning stops.
  always_comb begin
    blink_cnt_next   = blink_cnt;
    blink_phase_next = blink_phase;
    if (!enable) begin
      blink_cnt_next = '0;
    end else if (frame_tick) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt_next   = '0;
        blink_phase_next = ~blink_phase;
      end else begin
        blink_cnt_next = blink_cnt + KW'(1);
      end
    end
  end

  // Blink register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      blink_cnt   <= blink_cnt_next;
      blink_phase <= blink_phase_next;
    end
  end

  // Buffer updates: writes land in back; a pending commit copies back to front
  // in the frame_tick cycle, or straight away while idle.
  always_comb begin
    accept_wr     = wr_valid && wr_ready;
    accept_commit = wr_commit && wr_ready;
    swap          = pending && (frame_tick || (state == IDLE));
    for (int i = 0; i < NUM_DIGITS; i++) begin
      back_next[i]  = back[i];
      front_next[i] = swap ? back[i] : front[i];
      if (accept_wr && (wr_idx == 3'(i))) begin
        back_next[i] = wr_seg;
      end
    end
    pending_next = pending;
    if (swap) begin
      pending_next = 1'b0;
    end else if (accept_commit) begin
      pending_next = 1'b1;
    end
  end

  // Buffer and commit registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        front[i] <= SEG_OFF;
        back[i]  <= SEG_OFF;
      end
      pending <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        front[i] <= front_next[i];
        back[i]  <= back_next[i];
      end
      pending <= pending_next;
    end
  end

  assign drive_next  = (state_next == DRIVE);
  assign drive_entry = drive_next && (state != DRIVE);

  disp_pwm u_pwm (
    .clk         (clk),
    .rst         (rst),
    .drive_next  (drive_next),
    .drive_entry (drive_entry),
    .brightness  (brightness),
    .lit_next    (pwm_lit_next)
  );

  // Output values for the next cycle, so the first DRIVE cycle already shows the digit.
  always_comb begin
    show_next      = pwm_lit_next && !(blink_phase_next && blink_mask[idx_next]);
    seg_next       = SEG_OFF;
    digit_sel_next = DIGIT_NONE;
    if (show_next) begin
      seg_next       = front_next[idx_next];
      digit_sel_next = DIGIT_SEL[idx_next];
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg        <= SEG_OFF;
      digit_sel  <= DIGIT_NONE;
      frame_tick <= 1'b0;
      wr_ready   <= 1'b1;
    end else begin
      seg        <= seg_next;
      digit_sel  <= digit_sel_next;
      frame_tick <= tick_next;
      wr_ready   <= ~pending_next;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with short dwell/blank/blink parameters.
module tb_display_scan_ctrl;

  localparam int DWELL = 8;
  localparam int BLANKC = 2;
  localparam int BLINKF = 2;
  localparam int SLOT = DWELL + BLANKC;
  localparam int FRAME = 6 * SLOT;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       wr_valid;
  logic       wr_ready;
  logic [2:0] wr_idx;
  logic [7:0] wr_seg;
  logic       wr_commit;
  logic [3:0] brightness;
  logic [5:0] blink_mask;
  logic [7:0] seg;
  logic [5:0] digit_sel;
  logic       frame_tick;

  int total = 0;
  int bad = 0;
  int ticks = 0;
  logic [7:0] exp_front [6];
  logic [7:0] init_vals [6];

  // Clock
  always #5 clk = ~clk;

  display_scan_ctrl #(
    .DWELL_CYCLES (DWELL),
    .BLANK_CYCLES (BLANKC),
    .BLINK_FRAMES (BLINKF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_idx     (wr_idx),
    .wr_seg     (wr_seg),
    .wr_commit  (wr_commit),
    .brightness (brightness),
    .blink_mask (blink_mask),
    .seg        (seg),
    .digit_sel  (digit_sel),
    .frame_tick (frame_tick)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Walk one whole frame from its first cycle, comparing against an offset-based model.
  task automatic check_frame(input string name, input bit first);
    int k;
    int p;
    bit lit;
    bit phase;
    logic [7:0] es;
    logic [5:0] ed;
    logic [5:0] one;
    one = 6'b000001;
    phase = ((ticks / BLINKF) % 2) == 1;
    for (int o = 0; o < FRAME; o++) begin
      k = o / SLOT;
      p = o % SLOT;
      lit = (p >= BLANKC) && ((p - BLANKC) < int'(brightness)) && !(phase && blink_mask[k]);
      es = lit ? exp_front[k] : 8'hFF;
      ed = lit ? ~(one << k) : 6'h3F;
      check($sformatf("%s_o%0d_seg", name, o), 32'(seg), 32'(es));
      check($sformatf("%s_o%0d_sel", name, o), 32'(digit_sel), 32'(ed));
      check($sformatf("%s_o%0d_tick", name, o), 32'(frame_tick), 32'((o == 0) && !first));
      step();
    end
    check($sformatf("%s_end_tick", name), 32'(frame_tick), 32'(1));
    ticks++;
  endtask

  // Advance to the next frame_tick (bounded); optionally require dark segments meanwhile.
  task automatic wait_tick(input bit dark_check);
    int n;
    n = 0;
    while ((frame_tick !== 1'b1) && (n < 200)) begin
      if (dark_check) check("pre_commit_seg", 32'(seg), 32'(8'hFF));
      step();
      n++;
    end
    check("tick_seen", 32'(frame_tick), 32'(1));
    ticks++;
  endtask

  initial begin
    int n;
    init_vals[0] = 8'hC0; init_vals[1] = 8'hF9; init_vals[2] = 8'hA4;
    init_vals[3] = 8'hB0; init_vals[4] = 8'h99; init_vals[5] = 8'h92;
    rst = 1'b1; enable = 1'b0; wr_valid = 1'b0; wr_commit = 1'b0;
    wr_idx = 3'd0; wr_seg = 8'h00; brightness = 4'd15; blink_mask = 6'h00;
    repeat (3) step();
    check("rst_seg", 32'(seg), 32'(8'hFF));
    check("rst_sel", 32'(digit_sel), 32'(6'h3F));
    check("rst_tick", 32'(frame_tick), 32'(0));
    check("rst_ready", 32'(wr_ready), 32'(1));

    // 1: load back buffer, commit, swap only at frame boundary
    rst = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("t1_wr_ready", 32'(wr_ready), 32'(1));
      wr_valid = 1'b1; wr_idx = 3'(i); wr_seg = init_vals[i];
      step();
    end
    wr_valid = 1'b0;
    wr_commit = 1'b1;
    check("t1_commit_ready", 32'(wr_ready), 32'(1));
    step();
    wr_commit = 1'b0;
    check("t1_ready_drop", 32'(wr_ready), 32'(0));
    wait_tick(1'b1);
    for (int i = 0; i < 6; i++) exp_front[i] = init_vals[i];
    check_frame("t1", 1'b0);

    // 2: write+commit together; held write refused until the cycle after frame_tick
    wr_valid = 1'b1; wr_idx = 3'd0; wr_seg = 8'h80; wr_commit = 1'b1;
    check("t2_ready_pre", 32'(wr_ready), 32'(1));
    step();
    check("t2_ready_drop", 32'(wr_ready), 32'(0));
    wr_idx = 3'd1; wr_seg = 8'h11;
    n = 1;
    while ((frame_tick !== 1'b1) && (n < 200)) begin
      check("t2_ready_held", 32'(wr_ready), 32'(0));
      if (n == 3) wr_commit = 1'b0;
      step();
      n++;
    end
    wr_commit = 1'b0;
    check("t2_tick_seen", 32'(frame_tick), 32'(1));
    check("t2_ready_at_tick", 32'(wr_ready), 32'(0));
    ticks++;
    step();
    check("t2_ready_back", 32'(wr_ready), 32'(1));
    step();
    wr_valid = 1'b0;
    check("t2_ready_stays", 32'(wr_ready), 32'(1));
    wait_tick(1'b0);
    exp_front[0] = 8'h80;
    check_frame("t2a", 1'b0);
    check_frame("t2b", 1'b0);

    // 3: brightness 0 and 5
    brightness = 4'd0;
    check_frame("t3_b0", 1'b0);
    brightness = 4'd5;
    check_frame("t3_b5", 1'b0);
    brightness = 4'd15;

    // 4: blink digit 2 over four frames (two lit, two dark)
    blink_mask = 6'b000100;
    for (int f = 0; f < 4; f++) check_frame($sformatf("t4_f%0d", f), 1'b0);
    blink_mask = 6'h00;

    // 5: reset in the middle of digit 3's drive slot, with a commit pending
    wr_commit = 1'b1;
    step();
    wr_commit = 1'b0;
    for (int i = 1; i < 34; i++) step();
    check("t5_pre_seg", 32'(seg), 32'(8'hB0));
    check("t5_pre_sel", 32'(digit_sel), 32'(6'h37));
    check("t5_pre_ready", 32'(wr_ready), 32'(0));
    rst = 1'b1;
    #1;
    check("t5_rst_seg", 32'(seg), 32'(8'hFF));
    check("t5_rst_sel", 32'(digit_sel), 32'(6'h3F));
    check("t5_rst_ready", 32'(wr_ready), 32'(1));
    check("t5_rst_tick", 32'(frame_tick), 32'(0));
    step();
    rst = 1'b0;
    ticks = 0;
    step();
    step();
    check("t5_blank_sel", 32'(digit_sel), 32'(6'h3F));
    step();
    check("t5_d0_sel", 32'(digit_sel), 32'(6'h3E));
    check("t5_d0_seg", 32'(seg), 32'(8'hFF));

    // 6: drop enable with a commit pending, idle commit, dropped wr_idx=7 write
    wr_valid = 1'b1; wr_idx = 3'd2; wr_seg = 8'h5A; wr_commit = 1'b1;
    step();
    wr_valid = 1'b0; wr_commit = 1'b0;
    check("t6_ready_drop", 32'(wr_ready), 32'(0));
    step();
    check("t6_still_lit", 32'(digit_sel), 32'(6'h3E));
    enable = 1'b0;
    step();
    check("t6_idle_seg", 32'(seg), 32'(8'hFF));
    check("t6_idle_sel", 32'(digit_sel), 32'(6'h3F));
    check("t6_idle_ready", 32'(wr_ready), 32'(0));
    step();
    check("t6_swap_ready", 32'(wr_ready), 32'(1));
    wr_valid = 1'b1; wr_idx = 3'd7; wr_seg = 8'h00;
    step();
    wr_valid = 1'b0;
    wr_commit = 1'b1;
    check("t6_idx7_ready", 32'(wr_ready), 32'(1));
    step();
    wr_commit = 1'b0;
    check("t6_idle_commit_drop", 32'(wr_ready), 32'(0));
    step();
    check("t6_idle_commit_back", 32'(wr_ready), 32'(1));
    enable = 1'b1;
    step();
    for (int i = 0; i < 6; i++) exp_front[i] = 8'hFF;
    exp_front[2] = 8'h5A;
    check_frame("t6", 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
